vid_stream_gen: RTL and testbench

//  Source end of the vo_clk pixel stream (vsync/req/eol/eof/pixel) consumed by the overlay and

---
 rtl/vid_pkg.sv | 36 +++
 rtl/vid_pattern.sv | 26 ++
 rtl/vid_stream_gen.sv | 128 ++++++++++++
 tb/tb_vid_stream_gen.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// Shared encodings, default 1280x1024 raster timing and the colour-bar table
// for the vo_clk stream generator.
package vid_pkg;

    typedef enum logic [1:0] {
        PAT_SOLID   = 2'd0,
        PAT_BARS    = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_RAMP    = 2'd3
    } pattern_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } gen_state_e;

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_BLANK  = 408;
    localparam int DEF_V_ACTIVE = 1024;
    localparam int DEF_V_BLANK  = 42;

    // Left-to-right bar order: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

endpackage

// File: rtl/vid_pattern.sv
// Combinational pixel generator: picks the frame's latched pattern and
// produces the colour for the current raster position.
module vid_pattern
    import vid_pkg::*;
(
    input  pattern_e    pat,
    input  logic [7:0]  h_low,
    input  logic        v_bit4,
    input  logic [2:0]  bar_idx,
    input  logic [23:0] bg_color,
    output logic [23:0] pixel
);

    always_comb begin
        pixel = bg_color;
        case (pat)
            PAT_SOLID:   pixel = bg_color;
            PAT_BARS:    pixel = bar_color(bar_idx);
            // 16x16 squares: bit 4 of each coordinate selects the square parity.
            PAT_CHECKER: pixel = (h_low[4] ^ v_bit4) ? ~bg_color : bg_color;
            PAT_RAMP:    pixel = {h_low, h_low, h_low};
            default:     pixel = bg_color;
        endcase
    end

endmodule

// File: rtl/vid_stream_gen.sv
// Head of the video output pipeline: free-running raster counters, run/idle
// FSM and registered stream framing plus test-pattern pixel.
module vid_stream_gen
    import vid_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_BLANK  = DEF_V_BLANK
) (
    input  logic        vo_clk,
    input  logic        vo_reset_,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] bg_color,
    output logic        out_vsync,
    output logic        out_req,
    output logic        out_eol,
    output logic        out_eof,
    output logic [23:0] out_pixel,
    output gen_state_e  dbg_state
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
    localparam logic [11:0] H_ACT_LAST = 12'(H_ACTIVE - 1);
    localparam logic [11:0] BAR_LAST   = 12'(BAR_W - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] V_ACT_LAST = 11'(V_ACTIVE - 1);

    gen_state_e  state;
    logic [11:0] h_pos;
    logic [10:0] v_pos;
    logic [2:0]  bar_idx;
    logic [11:0] bar_cnt;
    pattern_e    pat_q;
    logic [23:0] pat_pixel;

    logic h_wrap, frame_wrap, req_d, eol_d, eof_d, vsync_d;

    // out_req is a valid-only strobe: one pixel per asserted cycle, no ready
    // input, so downstream stages must accept every cycle that req is high.
    assign h_wrap     = (h_pos == H_LAST);
    assign frame_wrap = h_wrap && (v_pos == V_LAST);
    assign req_d      = (state == ST_RUN) && (h_pos < H_ACT) && (v_pos < V_ACT);
    assign eol_d      = req_d && (h_pos == H_ACT_LAST);
    assign eof_d      = eol_d && (v_pos == V_ACT_LAST);
    assign vsync_d    = (state == ST_RUN) && (h_pos == 12'd0) && (v_pos == V_LAST);
    assign dbg_state  = state;

    vid_pattern u_pattern (
        .pat      (pat_q),
        .h_low    (h_pos[7:0]),
        .v_bit4   (v_pos[4]),
        .bar_idx  (bar_idx),
        .bg_color (bg_color),
        .pixel    (pat_pixel)
    );

    always_ff @(posedge vo_clk or negedge vo_reset_) begin
        if (!vo_reset_) begin
            state     <= ST_IDLE;
            h_pos     <= '0;
            v_pos     <= '0;
            bar_idx   <= '0;
            bar_cnt   <= '0;
            pat_q     <= PAT_SOLID;
            out_vsync <= 1'b0;
            out_req   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            out_pixel <= '0;
        end else begin
            out_vsync <= vsync_d;
            out_req   <= req_d;
            out_eol   <= eol_d;
            out_eof   <= eof_d;
            out_pixel <= req_d ? pat_pixel : 24'd0;
            if (vsync_d) begin
                pat_q <= pattern_e'(pattern_sel);
            end

            case (state)
                ST_IDLE: begin
                    // Start on the pre-frame line so vsync leads the first req.
                    if (enable) begin
                        state   <= ST_RUN;
                        h_pos   <= '0;
                        v_pos   <= V_LAST;
                        bar_idx <= '0;
                        bar_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (h_wrap) begin
                        h_pos   <= '0;
                        bar_idx <= '0;
                        bar_cnt <= '0;
                        if (frame_wrap) begin
                            v_pos <= '0;
                            if (!enable) begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            v_pos <= v_pos + 11'd1;
                        end
                    end else begin
                        h_pos <= h_pos + 12'd1;
                        // Bar index tracks h_pos without a divider.
                        if (bar_cnt == BAR_LAST) begin
                            bar_cnt <= '0;
                            bar_idx <= bar_idx + 3'd1;
                        end else begin
                            bar_cnt <= bar_cnt + 12'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vid_stream_gen.sv
// Directed bench for vid_stream_gen: small raster (16+4 x 8+2) plus a
// 64x32 instance for the checkerboard.
module tb_vid_stream_gen;
    import vid_pkg::*;

    localparam int FRAME   = 200;
    localparam int FRAME_B = 68 * 34;
    localparam int SEL_VSYNC   = 0;
    localparam int SEL_REQ     = 1;
    localparam int SEL_EOF     = 2;
    localparam int SEL_VSYNC_B = 3;

    logic        vo_clk;
    logic        vo_reset_;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [23:0] bg_color;
    logic        out_vsync, out_req, out_eol, out_eof;
    logic [23:0] out_pixel;
    gen_state_e  dbg_state;

    logic        enable_b;
    logic [1:0]  pattern_sel_b;
    logic [23:0] bg_color_b;
    logic        out_vsync_b, out_req_b, out_eol_b, out_eof_b;
    logic [23:0] out_pixel_b;
    gen_state_e  dbg_state_b;

    int total;
    int bad;
    logic [23:0] exp_q[$];
    logic [23:0] bars[8];

    // ---------------- clock / reset ----------------
    initial vo_clk = 1'b0;
    always #5 vo_clk = ~vo_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vid_stream_gen #(.H_ACTIVE(16), .H_BLANK(4), .V_ACTIVE(8), .V_BLANK(2)) dut (
        .vo_clk      (vo_clk),
        .vo_reset_   (vo_reset_),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .bg_color    (bg_color),
        .out_vsync   (out_vsync),
        .out_req     (out_req),
        .out_eol     (out_eol),
        .out_eof     (out_eof),
        .out_pixel   (out_pixel),
        .dbg_state   (dbg_state)
    );

    vid_stream_gen #(.H_ACTIVE(64), .H_BLANK(4), .V_ACTIVE(32), .V_BLANK(2)) dut_b (
        .vo_clk      (vo_clk),
        .vo_reset_   (vo_reset_),
        .enable      (enable_b),
        .pattern_sel (pattern_sel_b),
        .bg_color    (bg_color_b),
        .out_vsync   (out_vsync_b),
        .out_req     (out_req_b),
        .out_eol     (out_eol_b),
        .out_eof     (out_eof_b),
        .out_pixel   (out_pixel_b),
        .dbg_state   (dbg_state_b)
    );

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge vo_clk);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            SEL_VSYNC: return out_vsync;
            SEL_REQ:   return out_req;
            SEL_EOF:   return out_eof;
            default:   return out_vsync_b;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int sel, input int limit, output int n);
        n = 0;
        while (n < limit) begin
            tick();
            n++;
            if (sig(sel)) break;
        end
        check({tag, "_seen"}, 32'(sig(sel)), 32'd1);
    endtask

    // Runs FRAME cycles from a vsync, checking req pixels against exp_q.
    task automatic run_frame(input string tag);
        int nreq = 0, neol = 0, neof = 0, neof_eol = 0, nvs = 0, nz = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (out_vsync) nvs++;
            if (out_req) begin
                nreq++;
                if (exp_q.size() > 0) check({tag, "_pix"}, 32'(out_pixel), 32'(exp_q.pop_front()));
            end else if (out_pixel != 24'd0) begin
                nz++;
            end
            if (out_eol) neol++;
            if (out_eof) begin
                neof++;
                if (out_eol) neof_eol++;
            end
        end
        check({tag, "_req_cnt"}, nreq, 128);
        check({tag, "_eol_cnt"}, neol, 8);
        check({tag, "_eof_cnt"}, neof, 1);
        check({tag, "_eof_eol"}, neof_eol, 1);
        check({tag, "_vsync_cnt"}, nvs, 1);
        check({tag, "_idle_pix"}, nz, 0);
        check({tag, "_q_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic fill_solid(input logic [23:0] c);
        for (int k = 0; k < 128; k++) exp_q.push_back(c);
    endtask

    task automatic fill_bars();
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 16; x++) exp_q.push_back(bars[x / 2]);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n, x, y, hits, cnt;
        total = 0;
        bad = 0;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        vo_reset_     = 1'b0;
        enable        = 1'b1;
        pattern_sel   = 2'd0;
        bg_color      = 24'h123456;
        enable_b      = 1'b1;
        pattern_sel_b = 2'd2;
        bg_color_b    = 24'h000000;

        // 1: reset values, start-up latency, vsync period
        repeat (5) tick();
        check("t1_rst_vsync", out_vsync, 0);
        check("t1_rst_req", out_req, 0);
        check("t1_rst_eol", out_eol, 0);
        check("t1_rst_eof", out_eof, 0);
        check("t1_rst_pixel", out_pixel, 0);
        check("t1_rst_state", dbg_state, ST_IDLE);
        vo_reset_ = 1'b1;
        tick();
        check("t1_run_state", dbg_state, ST_RUN);
        check("t1_vsync_early", out_vsync, 0);
        tick();
        check("t1_vsync", out_vsync, 1);
        wait_for("t1_req", SEL_REQ, 100, n);
        check("t1_vsync_to_req", n, 20);
        wait_for("t1_vsync2", SEL_VSYNC, 400, n);
        check("t1_vsync_period", n + 20, FRAME);

        // 2: three solid frames
        for (int f = 0; f < 3; f++) begin
            fill_solid(24'h123456);
            run_frame("t2_solid");
        end

        // 3: colour bars take effect from the next vsync
        pattern_sel = 2'd1;
        fill_solid(24'h123456);
        run_frame("t3_pre");
        fill_bars();
        run_frame("t3_bars");

        // 4: checkerboard on the 64x32 instance
        wait_for("t4_vsync_b", SEL_VSYNC_B, 3000, n);
        x = 0;
        y = 0;
        hits = 0;
        for (int i = 0; i < FRAME_B; i++) begin
            tick();
            if (out_req_b) begin
                if (x == 0 && y == 0)   begin check("t4_0_0", out_pixel_b, 24'h000000); hits++; end
                if (x == 16 && y == 0)  begin check("t4_16_0", out_pixel_b, 24'hFFFFFF); hits++; end
                if (x == 16 && y == 16) begin check("t4_16_16", out_pixel_b, 24'h000000); hits++; end
                if (x == 0 && y == 16)  begin check("t4_0_16", out_pixel_b, 24'hFFFFFF); hits++; end
                if (x == 63 && y == 31) begin check("t4_63_31", out_pixel_b, 24'h000000); hits++; end
                x++;
                if (out_eol_b) begin
                    x = 0;
                    y++;
                end
            end
        end
        check("t4_hits", hits, 5);
        check("t4_lines", y, 32);

        // 5: drop enable mid-frame, frame completes, then idle
        pattern_sel = 2'd0;
        wait_for("t5_vsync", SEL_VSYNC, 300, n);
        repeat (50) tick();
        enable = 1'b0;
        wait_for("t5_eof", SEL_EOF, 300, n);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (out_req) cnt++;
        end
        check("t5_req_after_eof", cnt, 0);
        check("t5_idle_state", dbg_state, ST_IDLE);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_vsync || out_req || out_eol || out_eof || out_pixel != 24'd0) cnt++;
        end
        check("t5_idle_quiet", cnt, 0);
        bg_color = 24'h123456;
        enable = 1'b1;
        wait_for("t5_revsync", SEL_VSYNC, 10, n);
        check("t5_en_to_vsync", n, 2);
        wait_for("t5_rereq", SEL_REQ, 100, n);
        check("t5_vsync_to_req", n, 20);

        // 6: pattern change mid-frame only lands on the next frame
        check("t6_first_pix", out_pixel, 24'h123456);
        repeat (10) tick();
        pattern_sel = 2'd3;
        cnt = 0;
        for (int i = 0; i < 170; i++) begin
            tick();
            if (out_req && out_pixel != 24'h123456) cnt++;
        end
        check("t6_rest_solid", cnt, 0);
        check("t6_next_vsync", out_vsync, 1);
        x = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (out_req) begin
                if (x == 0)  check("t6_ramp_x0", out_pixel, 24'h000000);
                if (x == 5)  check("t6_ramp_x5", out_pixel, 24'h050505);
                if (x == 15) check("t6_ramp_x15", out_pixel, 24'h0F0F0F);
                x++;
                if (out_eol) x = 0;
            end
        end

        // 7: asynchronous reset mid-frame, restart with vsync first
        wait_for("t7_req", SEL_REQ, 300, n);
        #2;
        vo_reset_ = 1'b0;
        #1;
        check("t7_async_req", out_req, 0);
        check("t7_async_pixel", out_pixel, 0);
        check("t7_async_state", dbg_state, ST_IDLE);
        repeat (3) tick();
        vo_reset_ = 1'b1;
        n = 0;
        while (n < 50 && !out_vsync && !out_req) begin
            tick();
            n++;
        end
        check("t7_vsync_first", out_vsync, 1);
        check("t7_no_req_first", out_req, 0);
        wait_for("t7_req2", SEL_REQ, 100, n);
        check("t7_vsync_to_req", n, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
